display_scan_ctrl: RTL and testbench

Four-digit 7-segment scan controller for the board display. It time-multiplexes a 16-bit hex value across four common-anode digits using an internal prescaler, and decodes each nibble to segments. It supports per-digit enable, decimal points and leading-zero suppression. New values arrive through a load/ready handshake and take effect only at a frame boundary, so the display never shows a torn value. It sits between the datapath registers and the segment/anode pins.

---
 rtl/display_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with frame-synchronous
// value loading, per-digit enables, decimal points and leading-zero blanking.
module display_scan_ctrl #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  output logic        ready,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 7'b0000001;
      4'h1:    seg_decode = 7'b1001111;
      4'h2:    seg_decode = 7'b0010010;
      4'h3:    seg_decode = 7'b0000110;
      4'h4:    seg_decode = 7'b1001100;
      4'h5:    seg_decode = 7'b0100100;
      4'h6:    seg_decode = 7'b0100000;
      4'h7:    seg_decode = 7'b0001111;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0000100;
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b1100000;
      4'hC:    seg_decode = 7'b0110001;
      4'hD:    seg_decode = 7'b1000010;
      4'hE:    seg_decode = 7'b0110000;
      4'hF:    seg_decode = 7'b0111000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          frame_tick_q, frame_tick_d;
  logic          ready_q, ready_d;
  logic          pend_valid_q, pend_valid_d;
  logic [15:0]   pend_value_q, pend_value_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic [3:0]    pend_en_q, pend_en_d;
  logic          pend_lz_q, pend_lz_d;
  logic [15:0]   act_value_q, act_value_d;
  logic [3:0]    act_dp_q, act_dp_d;
  logic [3:0]    act_en_q, act_en_d;
  logic          act_lz_q, act_lz_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic          slot_tick_s;
  logic          boundary_s;
  logic          accept_s;
  logic [3:0]    nib_s;
  logic          suppress_s;
  logic          off_s;

  // Next-state for scan timing, handshake buffers and the registered pins
  always_comb begin
    slot_tick_s = (cnt_q == CNT_MAX);
    boundary_s  = slot_tick_s && (idx_q == 2'd3);
    accept_s    = load && ready_q;

    cnt_d        = slot_tick_s ? {CW{1'b0}} : (cnt_q + {{(CW-1){1'b0}}, 1'b1});
    idx_d        = slot_tick_s ? (idx_q + 2'd1) : idx_q;
    frame_tick_d = boundary_s;

    pend_valid_d = pend_valid_q;
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_lz_d    = pend_lz_q;
    act_value_d  = act_value_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    act_lz_d     = act_lz_q;

    if (boundary_s && pend_valid_q) begin
      act_value_d  = pend_value_q;
      act_dp_d     = pend_dp_q;
      act_en_d     = pend_en_q;
      act_lz_d     = pend_lz_q;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    // Accept and transfer are mutually exclusive: accept needs an empty buffer
    if (accept_s) begin
      pend_value_d = value;
      pend_dp_d    = dp_in;
      pend_en_d    = digit_en;
      pend_lz_d    = blank_lz;
      pend_valid_d = 1'b1;
    end else begin
      pend_lz_d    = pend_lz_d;
    end
    ready_d = !pend_valid_d;

    // A digit is blank when it and every more significant nibble are zero
    nib_s      = act_value_q[{idx_q, 2'b00} +: 4];
    suppress_s = act_lz_q && (idx_q != 2'd0) &&
                 ((act_value_q >> {idx_q, 2'b00}) == 16'h0000);
    off_s      = !act_en_q[idx_q] || suppress_s;

    if (off_s) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_decode(nib_s);
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q        <= {CW{1'b0}};
      idx_q        <= 2'd0;
      frame_tick_q <= 1'b0;
      ready_q      <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_value_q <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_en_q    <= 4'h0;
      pend_lz_q    <= 1'b0;
      act_value_q  <= 16'h0000;
      act_dp_q     <= 4'h0;
      act_en_q     <= 4'h0;
      act_lz_q     <= 1'b0;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      an_q         <= 4'b1111;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_tick_q <= frame_tick_d;
      ready_q      <= ready_d;
      pend_valid_q <= pend_valid_d;
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_lz_q    <= pend_lz_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      act_lz_q     <= act_lz_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign ready      = ready_q;
  assign frame_tick = frame_tick_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: two instances (PRESCALE=4 and PRESCALE=1) driven with
// directed and random loads, checked every cycle against a cycle-count model.
module tb_display_scan_ctrl;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ready;
    logic       ft;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;

  logic        ready4, dp4, ft4, ready1, dp1, ft1;
  logic [6:0]  seg4, seg1;
  logic [3:0]  an4, an1;

  int tests = 0;
  int fails = 0;

  obs_t exp4_q[$];
  obs_t exp1_q[$];

  always #5 clock = ~clock;

  display_scan_ctrl #(.PRESCALE(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .load(load), .ready(ready4),
    .value(value), .dp_in(dp_in), .digit_en(digit_en), .blank_lz(blank_lz),
    .seg(seg4), .dp(dp4), .an(an4), .frame_tick(ft4)
  );

  display_scan_ctrl #(.PRESCALE(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .load(load), .ready(ready1),
    .value(value), .dp_in(dp_in), .digit_en(digit_en), .blank_lz(blank_lz),
    .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1)
  );

  // Segment patterns for 0..F, active-low {a..g}
  logic [6:0] dec_tab [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model state, one slot per instance
  int          m_cyc   [2];
  logic [15:0] m_val   [2];
  logic [3:0]  m_dp    [2];
  logic [3:0]  m_en    [2];
  logic        m_lz    [2];
  logic        p_vld   [2];
  logic [15:0] p_val   [2];
  logic [3:0]  p_dp    [2];
  logic [3:0]  p_en    [2];
  logic        p_lz    [2];

  task automatic model_step(input int u, input int p, output obs_t o);
    int idx, top;
    logic [3:0] nib;
    logic [3:0] an_v;
    bit sup, off, boundary, rdy_now;
    if (!reset_n) begin
      m_cyc[u] = 0; m_val[u] = 16'h0; m_dp[u] = 4'h0; m_en[u] = 4'h0; m_lz[u] = 1'b0;
      p_vld[u] = 1'b0; p_val[u] = 16'h0; p_dp[u] = 4'h0; p_en[u] = 4'h0; p_lz[u] = 1'b0;
      o = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, ready: 1'b1, ft: 1'b0};
    end else begin
      idx = (m_cyc[u] / p) % 4;
      top = -1;
      for (int i = 3; i >= 0; i--)
        if (top < 0 && m_val[u][i*4 +: 4] != 4'h0) top = i;
      sup = m_lz[u] && idx != 0 && idx > top;
      off = !m_en[u][idx] || sup;
      nib = m_val[u][idx*4 +: 4];
      an_v = 4'b1111;
      an_v[idx] = 1'b0;
      o.an  = off ? 4'b1111 : an_v;
      o.seg = off ? 7'b1111111 : dec_tab[nib];
      o.dp  = off ? 1'b1 : ~m_dp[u][idx];
      boundary = (m_cyc[u] % (4 * p)) == (4 * p - 1);
      o.ft = boundary;
      rdy_now = !p_vld[u];
      if (boundary && p_vld[u]) begin
        m_val[u] = p_val[u]; m_dp[u] = p_dp[u]; m_en[u] = p_en[u]; m_lz[u] = p_lz[u];
        p_vld[u] = 1'b0;
      end
      if (load && rdy_now) begin
        p_val[u] = value; p_dp[u] = dp_in; p_en[u] = digit_en; p_lz[u] = blank_lz;
        p_vld[u] = 1'b1;
      end
      o.ready = !p_vld[u];
      m_cyc[u]++;
    end
  endtask

  // Model: at each active edge push what each DUT should show after it
  always @(posedge clock) begin
    obs_t o4, o1;
    model_step(0, 4, o4);
    exp4_q.push_back(o4);
    model_step(1, 1, o1);
    exp1_q.push_back(o1);
  end

  task automatic check(input string name, input obs_t got, input obs_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t got an=%b seg=%b dp=%b rdy=%b ft=%b want an=%b seg=%b dp=%b rdy=%b ft=%b",
               name, $time, got.an, got.seg, got.dp, got.ready, got.ft,
               want.an, want.seg, want.dp, want.ready, want.ft);
    end
  endtask

  // Monitor: pop one expectation per instance on each falling edge
  always @(negedge clock) begin
    obs_t g;
    if (exp4_q.size() == 0 || exp1_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty t=%0t got 0 entries want 1", $time);
    end else begin
      g = '{an: an4, seg: seg4, dp: dp4, ready: ready4, ft: ft4};
      check("p4", g, exp4_q.pop_front());
      g = '{an: an1, seg: seg1, dp: dp1, ready: ready1, ft: ft1};
      check("p1", g, exp1_q.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] e, input logic lz);
    value = v; dp_in = d; digit_en = e; blank_lz = lz; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0; digit_en = 4'h0; blank_lz = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    do_load(16'h3C7E, 4'hA, 4'hF, 1'b0);
    cyc(6);
    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(5);
    do_load(16'h12AF, 4'h0, 4'hF, 1'b0);
    do_load(16'hFFFF, 4'hF, 4'hF, 1'b0);
    cyc(40);
    do_load(16'h0005, 4'h0, 4'hF, 1'b1);
    cyc(40);
    do_load(16'h0000, 4'h0, 4'hF, 1'b1);
    cyc(40);
    do_load(16'h0340, 4'hF, 4'hF, 1'b1);
    cyc(40);
    do_load(16'h9B8D, 4'b0100, 4'b0101, 1'b0);
    cyc(40);
    for (int k = 0; k < 16; k++) begin
      cyc(k);
      do_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      cyc(20);
    end
    for (int k = 0; k < 3000; k++) begin
      reset_n  = ($urandom_range(0, 299) != 0);
      load     = ($urandom_range(0, 5) == 0);
      value    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in    = 4'($urandom);
      digit_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      blank_lz = 1'($urandom);
      cyc(1);
    end
    reset_n = 1'b1;
    load = 1'b0;
    cyc(3);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
